// File: rtl/kyber_pkg.sv
// Shared Kyber constants, FSM state type and exact mod-q arithmetic helpers
// used by the NTT-domain matrix-vector accumulator.
package kyber_pkg;

    localparam int KYBER_Q = 3329;
    localparam int KYBER_K = 3;
    localparam int KYBER_N = 256;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_MAC   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Barrett reduction for x < 2^24 with m = floor(2^24 / q); the quotient
    // estimate is off by at most one, so a single conditional subtract suffices.
    function automatic logic [11:0] mod_q(input logic [23:0] x);
        logic [36:0] prod;
        logic [12:0] quo;
        logic [24:0] rem;
        prod = {13'd0, x} * 37'(5039);
        quo  = prod[36:24];
        rem  = {1'b0, x} - ({12'd0, quo} * 25'(KYBER_Q));
        if (rem >= 25'(KYBER_Q)) begin
            rem = rem - 25'(KYBER_Q);
        end
        return rem[11:0];
    endfunction

    function automatic logic [11:0] add_mod(input logic [11:0] a, input logic [11:0] b);
        logic [12:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 13'(KYBER_Q)) begin
            s = s - 13'(KYBER_Q);
        end
        return s[11:0];
    endfunction

    // GAMMA[i] = 17^(2*BitRev7(i)+1) mod q, built at elaboration by square-and-multiply.
    function automatic logic [127:0][11:0] gen_gamma();
        logic [127:0][11:0] tbl;
        int br;
        int e;
        int base;
        int acc;
        for (int i = 0; i < 128; i++) begin
            br = 0;
            for (int b = 0; b < 7; b++) begin
                if (((i >> b) & 1) == 1) br = br | (1 << (6 - b));
            end
            e    = 2 * br + 1;
            acc  = 1;
            base = 17;
            for (int b = 0; b < 8; b++) begin
                if (((e >> b) & 1) == 1) acc = (acc * base) % KYBER_Q;
                base = (base * base) % KYBER_Q;
            end
            tbl[i] = 12'(acc);
        end
        return tbl;
    endfunction

    localparam logic [127:0][11:0] GAMMA = gen_gamma();

endpackage

// File: rtl/basemul_pair.sv
// Two-stage base-case multiplier for one coefficient pair in Z_q[X]/(X^2 - gamma).
// Stage 1 forms the four reduced cross products, stage 2 folds them into (c0, c1).
module basemul_pair
    import kyber_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] a0,
    input  logic [11:0] a1,
    input  logic [11:0] b0,
    input  logic [11:0] b1,
    input  logic [11:0] gamma,
    output logic [11:0] c0,
    output logic [11:0] c1
);

    logic [11:0] p00_reg;
    logic [11:0] p11_reg;
    logic [11:0] p01_reg;
    logic [11:0] p10_reg;
    logic [11:0] gamma_reg;
    logic [11:0] c0_reg;
    logic [11:0] c1_reg;
    logic [11:0] p11_gamma;

    always_comb begin
        p11_gamma = mod_q(24'(p11_reg) * 24'(gamma_reg));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p00_reg   <= '0;
            p11_reg   <= '0;
            p01_reg   <= '0;
            p10_reg   <= '0;
            gamma_reg <= '0;
            c0_reg    <= '0;
            c1_reg    <= '0;
        end else begin
            p00_reg   <= mod_q(24'(a0) * 24'(b0));
            p11_reg   <= mod_q(24'(a1) * 24'(b1));
            p01_reg   <= mod_q(24'(a0) * 24'(b1));
            p10_reg   <= mod_q(24'(a1) * 24'(b0));
            gamma_reg <= gamma;
            c0_reg    <= add_mod(p00_reg, p11_gamma);
            c1_reg    <= add_mod(p01_reg, p10_reg);
        end
    end

    assign c0 = c0_reg;
    assign c1 = c1_reg;

endmodule

// File: rtl/ntt_matvec_acc.sv
// Accumulates u_hat = A^T * r_hat in the NTT domain: each accepted matrix polynomial
// is base-multiplied against r_hat[row] and summed mod q into u_hat[col].
module ntt_matvec_acc
    import kyber_pkg::*;
#(
    parameter int K = KYBER_K,
    parameter int N = KYBER_N
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [K*N*16-1:0] r_hat,
    input  logic              poly_valid,
    input  logic [3:0]        poly_index,
    input  logic [N*16-1:0]   poly_in,
    output logic              poly_ready,
    output logic              done,
    output logic              error,
    output logic [K*N*16-1:0] u_hat
);

    localparam int RW = $clog2(K);
    localparam int PW = $clog2(N / 2);

    state_t state_reg;
    state_t state_next;

    logic [K-1:0][N-1:0][11:0] acc_reg;
    logic [N-1:0][11:0]        buf_reg;
    logic [N-1:0][11:0]        poly_low;
    logic [K-1:0][N-1:0][11:0] r_low;
    logic [N-1:0][3:0]         poly_hi;
    logic [K-1:0][N-1:0][3:0]  r_hi;
    logic                      unused_hi;

    logic [RW-1:0] row_reg;
    logic [RW-1:0] col_reg;
    logic [PW-1:0] pair_reg;
    logic          issuing_reg;
    logic          v1_reg;
    logic          v2_reg;
    logic [PW-1:0] idx1_reg;
    logic [PW-1:0] idx2_reg;
    logic [3:0]    poly_cnt_reg;
    logic          error_reg;

    logic          index_ok;
    logic          accept;
    logic          drop;
    logic          clear;
    logic          issue;
    logic          last_wb;
    logic [11:0]   c0;
    logic [11:0]   c1;

    genvar gi, gj;
    generate
        for (gi = 0; gi < N; gi++) begin : g_poly
            assign poly_low[gi] = poly_in[16*gi +: 12];
            assign poly_hi[gi]  = poly_in[16*gi+12 +: 4];
        end
        for (gj = 0; gj < K; gj++) begin : g_rank
            for (gi = 0; gi < N; gi++) begin : g_coef
                assign r_low[gj][gi] = r_hat[16*(gj*N+gi) +: 12];
                assign r_hi[gj][gi]  = r_hat[16*(gj*N+gi)+12 +: 4];
                assign u_hat[16*(gj*N+gi) +: 16] = {4'd0, acc_reg[gj][gi]};
            end
        end
    endgenerate

    // Coefficients are guaranteed reduced; the upper nibbles carry no information.
    assign unused_hi = ^{poly_hi, r_hi};

    assign index_ok = (poly_index <= 4'(K*K-1));
    assign accept   = (state_reg == ST_ARMED) && poly_valid && index_ok;
    assign drop     = poly_valid && ((state_reg != ST_ARMED) || !index_ok);
    assign clear    = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
    assign issue    = (state_reg == ST_MAC) && issuing_reg;
    assign last_wb  = v2_reg && (idx2_reg == '1);

    basemul_pair u_basemul (
        .clk   (clk),
        .rst   (rst),
        .a0    (buf_reg[{pair_reg, 1'b0}]),
        .a1    (buf_reg[{pair_reg, 1'b1}]),
        .b0    (r_low[row_reg][{pair_reg, 1'b0}]),
        .b1    (r_low[row_reg][{pair_reg, 1'b1}]),
        .gamma (GAMMA[pair_reg]),
        .c0    (c0),
        .c1    (c1)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start) state_next = ST_ARMED;
            ST_ARMED: if (accept) state_next = ST_MAC;
            ST_MAC: begin
                if (last_wb) begin
                    state_next = (poly_cnt_reg == 4'(K*K-1)) ? ST_DONE : ST_ARMED;
                end
            end
            ST_DONE:  if (start) state_next = ST_ARMED;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        poly_ready = (state_reg == ST_ARMED);
        done       = (state_reg == ST_DONE);
    end

    assign error = error_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg      <= '0;
            buf_reg      <= '0;
            row_reg      <= '0;
            col_reg      <= '0;
            pair_reg     <= '0;
            issuing_reg  <= 1'b0;
            v1_reg       <= 1'b0;
            v2_reg       <= 1'b0;
            idx1_reg     <= '0;
            idx2_reg     <= '0;
            poly_cnt_reg <= '0;
            error_reg    <= 1'b0;
        end else begin
            if (clear) begin
                acc_reg      <= '0;
                poly_cnt_reg <= '0;
            end
            // A drop in the same cycle as a restart still leaves the flag set.
            if (drop) begin
                error_reg <= 1'b1;
            end else if (clear) begin
                error_reg <= 1'b0;
            end
            if (accept) begin
                buf_reg     <= poly_low;
                row_reg     <= RW'(poly_index / 4'(K));
                col_reg     <= RW'(poly_index % 4'(K));
                pair_reg    <= '0;
                issuing_reg <= 1'b1;
            end else if (issue) begin
                pair_reg <= pair_reg + PW'(1);
                if (pair_reg == '1) issuing_reg <= 1'b0;
            end
            v1_reg   <= issue;
            idx1_reg <= pair_reg;
            v2_reg   <= v1_reg;
            idx2_reg <= idx1_reg;
            if (v2_reg) begin
                acc_reg[col_reg][{idx2_reg, 1'b0}] <= add_mod(acc_reg[col_reg][{idx2_reg, 1'b0}], c0);
                acc_reg[col_reg][{idx2_reg, 1'b1}] <= add_mod(acc_reg[col_reg][{idx2_reg, 1'b1}], c1);
            end
            if (last_wb) begin
                poly_cnt_reg <= poly_cnt_reg + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_ntt_matvec_acc.sv
// Directed bench for ntt_matvec_acc: reset, product, gamma path, wrap, drops,
// mid-MAC reset and a full nine-polynomial run against a reference model.
module tb_ntt_matvec_acc;

    localparam int Q = 3329;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           poly_valid = 1'b0;
    logic [3:0]     poly_index = 4'd0;
    logic [4095:0]  poly_in = '0;
    logic [12287:0] r_hat = '0;
    logic [12287:0] u_hat;
    logic           poly_ready;
    logic           done;
    logic           error;

    int tests_run = 0;
    int tests_failed = 0;

    int r_model [3][256];
    int a_model [256];
    int exp_u   [3][256];

    ntt_matvec_acc dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .r_hat      (r_hat),
        .poly_valid (poly_valid),
        .poly_index (poly_index),
        .poly_in    (poly_in),
        .poly_ready (poly_ready),
        .done       (done),
        .error      (error),
        .u_hat      (u_hat)
    );

    always #5 clk = ~clk;

    function automatic int tb_gamma(input int i);
        int br;
        int e;
        int p;
        br = 0;
        for (int b = 0; b < 7; b++) begin
            if (((i >> b) & 1) == 1) br = br | (1 << (6 - b));
        end
        e = 2 * br + 1;
        p = 1;
        for (int k = 0; k < e; k++) p = (p * 17) % Q;
        return p;
    endfunction

    function automatic int count_diff(output int first_idx, output int got_val, output int want_val);
        int nd;
        int g;
        nd = 0;
        first_idx = -1;
        got_val = 0;
        want_val = 0;
        for (int j = 0; j < 3; j++) begin
            for (int c = 0; c < 256; c++) begin
                g = int'(u_hat[16*(256*j+c) +: 16]);
                if (g != exp_u[j][c]) begin
                    if (nd == 0) begin
                        first_idx = 256 * j + c;
                        got_val = g;
                        want_val = exp_u[j][c];
                    end
                    nd++;
                end
            end
        end
        return nd;
    endfunction

    task automatic clear_models();
        for (int j = 0; j < 3; j++) begin
            for (int c = 0; c < 256; c++) begin
                r_model[j][c] = 0;
                exp_u[j][c] = 0;
            end
        end
        for (int c = 0; c < 256; c++) a_model[c] = 0;
    endtask

    task automatic load_rhat();
        for (int j = 0; j < 3; j++) begin
            for (int c = 0; c < 256; c++) r_hat[16*(256*j+c) +: 16] = 16'(r_model[j][c]);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        poly_valid = 1'b0;
        poly_index = 4'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns just after the edge on which poly_valid was sampled.
    task automatic send_poly(input int idx);
        for (int c = 0; c < 256; c++) poly_in[16*c +: 16] = 16'(a_model[c]);
        @(negedge clk);
        poly_valid = 1'b1;
        poly_index = 4'(idx);
        @(negedge clk);
        poly_valid = 1'b0;
        $display("[TB] poly idx=%0d presented at %0t", idx, $time);
    endtask

    task automatic wait_free(output int cycles);
        cycles = -1;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (poly_ready || done) begin
                cycles = n;
                break;
            end
        end
    endtask

    task automatic model_accumulate(input int idx);
        int row;
        int col;
        int a0, a1, b0, b1, c0, c1;
        row = idx / 3;
        col = idx % 3;
        for (int i = 0; i < 128; i++) begin
            a0 = a_model[2*i];
            a1 = a_model[2*i+1];
            b0 = r_model[row][2*i];
            b1 = r_model[row][2*i+1];
            c0 = (a0 * b0 + ((a1 * b1) % Q) * tb_gamma(i)) % Q;
            c1 = (a0 * b1 + a1 * b0) % Q;
            exp_u[col][2*i]   = (exp_u[col][2*i] + c0) % Q;
            exp_u[col][2*i+1] = (exp_u[col][2*i+1] + c1) % Q;
        end
    endtask

    task automatic test_reset();
        int nd, fi, gv, wv;
        clear_models();
        do_reset();
        tests_run++;
        if (poly_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %b want 0", poly_ready); end
        tests_run++;
        if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", done); end
        tests_run++;
        if (error !== 1'b0) begin tests_failed++; $display("FAIL reset_error: got %b want 0", error); end
        nd = count_diff(fi, gv, wv);
        tests_run++;
        if (nd != 0) begin tests_failed++; $display("FAIL reset_uhat: %0d coeffs differ, first [%0d] got %0d want %0d", nd, fi, gv, wv); end
    endtask

    task automatic test_basic();
        int nd, fi, gv, wv, cyc;
        clear_models();
        r_model[0][0] = 1;
        load_rhat();
        pulse_start();
        tests_run++;
        if (poly_ready !== 1'b1) begin tests_failed++; $display("FAIL start_ready: got %b want 1", poly_ready); end
        a_model[0] = 5;
        send_poly(0);
        tests_run++;
        if (poly_ready !== 1'b0) begin tests_failed++; $display("FAIL mac_busy: got %b want 0", poly_ready); end
        wait_free(cyc);
        tests_run++;
        if (cyc != 130) begin tests_failed++; $display("FAIL basic_latency: got %0d want 130", cyc); end
        exp_u[0][0] = 5;
        nd = count_diff(fi, gv, wv);
        tests_run++;
        if (nd != 0) begin tests_failed++; $display("FAIL basic_uhat: %0d coeffs differ, first [%0d] got %0d want %0d", nd, fi, gv, wv); end
        tests_run++;
        if (done !== 1'b0) begin tests_failed++; $display("FAIL basic_done: got %b want 0", done); end
    endtask

    task automatic test_gamma();
        int nd, fi, gv, wv, cyc;
        do_reset();
        clear_models();
        r_model[0][1] = 1;
        r_model[0][3] = 1;
        load_rhat();
        pulse_start();
        a_model[1] = 1;
        a_model[3] = 1;
        send_poly(0);
        wait_free(cyc);
        tests_run++;
        if (cyc < 0) begin tests_failed++; $display("FAIL gamma_timeout: got %0d want >0", cyc); end
        exp_u[0][0] = 17;
        exp_u[0][2] = 3312;
        nd = count_diff(fi, gv, wv);
        tests_run++;
        if (nd != 0) begin tests_failed++; $display("FAIL gamma_uhat: %0d coeffs differ, first [%0d] got %0d want %0d", nd, fi, gv, wv); end
    endtask

    task automatic test_accum_wrap();
        int nd, fi, gv, wv, cyc;
        do_reset();
        clear_models();
        for (int j = 0; j < 3; j++) r_model[j][0] = 1;
        load_rhat();
        pulse_start();
        a_model[0] = 3000;
        for (int k = 0; k < 3; k++) begin
            send_poly(3 * k);
            wait_free(cyc);
            tests_run++;
            if (cyc < 0) begin tests_failed++; $display("FAIL wrap_timeout: got %0d want >0", cyc); end
        end
        exp_u[0][0] = 2342;
        nd = count_diff(fi, gv, wv);
        tests_run++;
        if (nd != 0) begin tests_failed++; $display("FAIL wrap_uhat: %0d coeffs differ, first [%0d] got %0d want %0d", nd, fi, gv, wv); end
        tests_run++;
        if (done !== 1'b0) begin tests_failed++; $display("FAIL wrap_done: got %b want 0", done); end
    endtask

    task automatic test_overflow();
        int nd, fi, gv, wv, cyc;
        do_reset();
        clear_models();
        r_model[0][0] = 1;
        load_rhat();
        pulse_start();
        a_model[0] = 7;
        send_poly(0);
        repeat (49) @(negedge clk);
        tests_run++;
        if (error !== 1'b0) begin tests_failed++; $display("FAIL pre_overflow_error: got %b want 0", error); end
        a_model[0] = 100;
        send_poly(0);
        tests_run++;
        if (error !== 1'b1) begin tests_failed++; $display("FAIL overflow_error: got %b want 1", error); end
        wait_free(cyc);
        exp_u[0][0] = 7;
        nd = count_diff(fi, gv, wv);
        tests_run++;
        if (nd != 0) begin tests_failed++; $display("FAIL overflow_uhat: %0d coeffs differ, first [%0d] got %0d want %0d", nd, fi, gv, wv); end
        tests_run++;
        if (poly_ready !== 1'b1) begin tests_failed++; $display("FAIL overflow_ready: got %b want 1", poly_ready); end

        do_reset();
        pulse_start();
        tests_run++;
        if (error !== 1'b0) begin tests_failed++; $display("FAIL bad_index_pre: got %b want 0", error); end
        a_model[0] = 7;
        send_poly(9);
        tests_run++;
        if (error !== 1'b1) begin tests_failed++; $display("FAIL bad_index_error: got %b want 1", error); end
        repeat (140) @(negedge clk);
        tests_run++;
        if (poly_ready !== 1'b1) begin tests_failed++; $display("FAIL bad_index_armed: got %b want 1", poly_ready); end
        exp_u[0][0] = 0;
        nd = count_diff(fi, gv, wv);
        tests_run++;
        if (nd != 0) begin tests_failed++; $display("FAIL bad_index_uhat: %0d coeffs differ, first [%0d] got %0d want %0d", nd, fi, gv, wv); end
    endtask

    task automatic test_reset_mid_mac();
        int nd, fi, gv, wv;
        do_reset();
        clear_models();
        r_model[0][0] = 1;
        load_rhat();
        pulse_start();
        a_model[0] = 9;
        send_poly(0);
        repeat (59) @(negedge clk);
        rst = 1'b1;
        #1;
        tests_run++;
        if ({poly_ready, done, error} !== 3'b000) begin
            tests_failed++;
            $display("FAIL midmac_flags: got ready/done/error=%b want 000", {poly_ready, done, error});
        end
        nd = count_diff(fi, gv, wv);
        tests_run++;
        if (nd != 0) begin tests_failed++; $display("FAIL midmac_uhat: %0d coeffs differ, first [%0d] got %0d want %0d", nd, fi, gv, wv); end
        @(negedge clk);
        rst = 1'b0;
        repeat (80) @(negedge clk);
        nd = count_diff(fi, gv, wv);
        tests_run++;
        if (nd != 0) begin tests_failed++; $display("FAIL midmac_flush: %0d coeffs differ, first [%0d] got %0d want %0d", nd, fi, gv, wv); end
        tests_run++;
        if (poly_ready !== 1'b0) begin tests_failed++; $display("FAIL midmac_idle: got %b want 0", poly_ready); end
    endtask

    task automatic test_full_run();
        int nd, fi, gv, wv, cyc;
        clear_models();
        for (int j = 0; j < 3; j++) begin
            for (int c = 0; c < 256; c++) r_model[j][c] = int'($urandom_range(0, Q - 1));
        end
        load_rhat();
        pulse_start();
        for (int p = 0; p < 9; p++) begin
            for (int c = 0; c < 256; c++) a_model[c] = int'($urandom_range(0, Q - 1));
            send_poly(p);
            model_accumulate(p);
            if (p < 8) begin
                wait_free(cyc);
                tests_run++;
                if (cyc != 130) begin tests_failed++; $display("FAIL full_latency: got %0d want 130", cyc); end
                repeat ($urandom_range(0, 20)) @(negedge clk);
            end
        end
        // done is first sampled by a registered consumer at T9+131.
        repeat (129) @(negedge clk);
        tests_run++;
        if (done !== 1'b0) begin tests_failed++; $display("FAIL full_done_early: got %b want 0", done); end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b1) begin tests_failed++; $display("FAIL full_done_rise: got %b want 1", done); end
        nd = count_diff(fi, gv, wv);
        tests_run++;
        if (nd != 0) begin tests_failed++; $display("FAIL full_uhat: %0d coeffs differ, first [%0d] got %0d want %0d", nd, fi, gv, wv); end
        tests_run++;
        if (error !== 1'b0) begin tests_failed++; $display("FAIL full_error: got %b want 0", error); end
        repeat (20) @(negedge clk);
        tests_run++;
        if (done !== 1'b1) begin tests_failed++; $display("FAIL full_done_hold: got %b want 1", done); end
    endtask

    task automatic test_restart();
        int nd, fi, gv, wv;
        pulse_start();
        tests_run++;
        if ({done, poly_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL restart_flags: got done/ready=%b want 01", {done, poly_ready});
        end
        for (int j = 0; j < 3; j++) begin
            for (int c = 0; c < 256; c++) exp_u[j][c] = 0;
        end
        nd = count_diff(fi, gv, wv);
        tests_run++;
        if (nd != 0) begin tests_failed++; $display("FAIL restart_uhat: %0d coeffs differ, first [%0d] got %0d want %0d", nd, fi, gv, wv); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gamma();
        test_accum_wrap();
        test_overflow();
        test_reset_mid_mac();
        test_full_run();
        test_restart();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
